ifu_fetch: RTL and testbench

- Instruction fetch unit for the multi-cycle NPC core.
- Consumes the next-PC value produced by branch resolution, issues an instruction read on an AXI4-Lite-style read channel, and hands the fetched word to decode.
- Non-pipelined: one instruction is in flight; the next fetch starts only after the core returns the resolved next PC.

---
 rtl/ifu_fetch.sv | 108 ++++++++++
 tb/tb_ifu_fetch.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one fetch in flight, AXI4-Lite-style read channel,
// hands the fetched word (or an error code) to decode, then waits for the next PC.
module ifu_fetch #(
  parameter int unsigned       PC_W     = 32,
  parameter int unsigned       INST_W   = 32,
  parameter logic [PC_W-1:0]   RESET_PC = 32'h8000_0000
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              npc_valid_i,
  input  logic [PC_W-1:0]   npc_i,
  output logic [PC_W-1:0]   araddr_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  input  logic [INST_W-1:0] rdata_i,
  input  logic [1:0]        rresp_i,
  input  logic              rvalid_i,
  output logic              rready_o,
  output logic [INST_W-1:0] inst_o,
  output logic [PC_W-1:0]   pc_o,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [1:0]        fetch_err_o
);

  localparam int unsigned ERR_W = 2;

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    CHK   = 3'd1,
    AR    = 3'd2,
    R     = 3'd3,
    OUT   = 3'd4,
    WAIT  = 3'd5
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [PC_W-1:0]    pc;
  logic [INST_W-1:0]  inst;
  logic [ERR_W-1:0]   err;
  logic               arvalid;
  logic               rready;
  logic               inst_valid;
  logic               misaligned;

  assign misaligned = (pc[1:0] != 2'b00);

  // Next-state decode; each handshake input only matters in its own state.
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = CHK;
      CHK:     state_nxt = misaligned ? OUT : AR;
      AR:      if (arready_i)    state_nxt = R;
      R:       if (rvalid_i)     state_nxt = OUT;
      OUT:     if (inst_ready_i) state_nxt = WAIT;
      WAIT:    if (npc_valid_i)  state_nxt = CHK;
      default: state_nxt = BOOT;
    endcase
  end

  // State, PC, payload and handshake flags; flags follow the next state so they are registered.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      inst       <= '0;
      err        <= '0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      inst_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      arvalid    <= (state_nxt == AR);
      rready     <= (state_nxt == R);
      inst_valid <= (state_nxt == OUT);
      if (state == CHK && misaligned) begin
        inst <= '0;
        err  <= ERR_W'(2);
      end
      if (state == R && rvalid_i) begin
        inst <= rdata_i;
        err  <= (rresp_i == 2'b00) ? ERR_W'(0) : ERR_W'(1);
      end
      if (state == WAIT && npc_valid_i) begin
        pc <= npc_i;
      end
    end
  end

  assign araddr_o     = pc;
  assign pc_o         = pc;
  assign arvalid_o    = arvalid;
  assign rready_o     = rready;
  assign inst_valid_o = inst_valid;
  assign inst_o       = inst;
  assign fetch_err_o  = err;

  // A next-PC pulse outside WAIT is lost; flag it as a protocol violation.
  npc_only_in_wait: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    npc_valid_i |-> (state == WAIT));

  // The address request is held stable until accepted.
  ar_held: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (arvalid_o && !arready_i) |=> (arvalid_o && $stable(araddr_o)));

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: a bus-slave driver with programmable delays
// and a scoreboard of expected {inst, pc, err} popped when decode sees inst_valid.
module tb_ifu_fetch;

  logic        clk;
  logic        rst_n;
  logic        npc_valid;
  logic [31:0] npc;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [1:0]  fetch_err;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [1:0]  err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   ar_hs   = 0;

  ifu_fetch dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .npc_valid_i  (npc_valid),
    .npc_i        (npc),
    .araddr_o     (araddr),
    .arvalid_o    (arvalid),
    .arready_i    (arready),
    .rdata_i      (rdata),
    .rresp_i      (rresp),
    .rvalid_i     (rvalid),
    .rready_o     (rready),
    .inst_o       (inst),
    .pc_o         (pc),
    .inst_valid_o (inst_valid),
    .inst_ready_i (inst_ready),
    .fetch_err_o  (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count accepted address handshakes.
  always @(posedge clk) if (rst_n && arvalid && arready) ar_hs <= ar_hs + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for inst_valid, then compare against the scoreboard head.
  task automatic consume(input int rdy_dly);
    exp_t e;
    int   n = 0;
    while (!inst_valid && n < 20) begin @(negedge clk); n++; end
    check("inst_valid_seen", 32'(inst_valid), 32'd1);
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check("inst", inst, e.inst);
    check("pc", pc, e.pc);
    check("err", 32'(fetch_err), 32'(e.err));
    repeat (rdy_dly) begin
      @(negedge clk);
      check("inst_valid_hold", 32'(inst_valid), 32'd1);
      check("inst_hold", inst, e.inst);
      check("err_hold", 32'(fetch_err), 32'(e.err));
    end
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    check("inst_valid_drop", 32'(inst_valid), 32'd0);
  endtask

  // Serve one read: hold arready off for ar_dly cycles, return data r_dly cycles after R entry.
  task automatic do_fetch(input int ar_dly, input int r_dly, input logic [31:0] data,
                          input logic [1:0] resp, input int rdy_dly, input logic [31:0] exp_pc);
    int n = 0;
    int hs0;
    hs0 = ar_hs;
    while (!arvalid && n < 20) begin @(negedge clk); n++; end
    check("arvalid_seen", 32'(arvalid), 32'd1);
    check("araddr", araddr, exp_pc);
    repeat (ar_dly) begin
      @(negedge clk);
      check("arvalid_hold", 32'(arvalid), 32'd1);
      check("araddr_hold", araddr, exp_pc);
    end
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    check("arvalid_drop", 32'(arvalid), 32'd0);
    check("rready", 32'(rready), 32'd1);
    repeat (r_dly) @(negedge clk);
    rvalid = 1'b1;
    rdata  = data;
    rresp  = resp;
    sb.push_back('{inst: data, pc: exp_pc, err: (resp == 2'b00) ? 2'd0 : 2'd1});
    @(negedge clk);
    rvalid = 1'b0;
    rdata  = '0;
    rresp  = '0;
    check("rvalid_to_inst_valid", 32'(inst_valid), 32'd1);
    consume(rdy_dly);
    check("one_ar_handshake", 32'(ar_hs - hs0), 32'd1);
  endtask

  // One-cycle next-PC pulse (only issued while the DUT waits).
  task automatic pulse_npc(input logic [31:0] a);
    npc_valid = 1'b1;
    npc       = a;
    @(negedge clk);
    npc_valid = 1'b0;
  endtask

  // Release reset and confirm the first request appears two cycles later.
  task automatic release_reset();
    rst_n = 1'b1;
    @(negedge clk);
    check("boot_no_arvalid", 32'(arvalid), 32'd0);
    @(negedge clk);
    check("boot_arvalid_c2", 32'(arvalid), 32'd1);
    check("boot_araddr", araddr, 32'h8000_0000);
  endtask

  initial begin
    rst_n = 1'b0; npc_valid = 1'b0; npc = '0; arready = 1'b0;
    rdata = '0; rresp = '0; rvalid = 1'b0; inst_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_arvalid", 32'(arvalid), 32'd0);
    check("rst_rready", 32'(rready), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_err", 32'(fetch_err), 32'd0);
    check("rst_pc", pc, 32'h8000_0000);

    // Boot fetch, no backpressure.
    release_reset();
    do_fetch(0, 0, 32'h0000_0413, 2'b00, 0, 32'h8000_0000);

    // Redirect: request appears two cycles after the pulse.
    pulse_npc(32'h8000_0100);
    check("redir_chk_no_arvalid", 32'(arvalid), 32'd0);
    @(negedge clk);
    check("redir_arvalid", 32'(arvalid), 32'd1);
    check("redir_araddr", araddr, 32'h8000_0100);
    // Backpressure on both address and decode sides.
    do_fetch(3, 2, 32'h1234_5678, 2'b00, 4, 32'h8000_0100);

    // Misaligned PC: no bus request, error code 2.
    begin
      int hs0;
      int saw_ar = 0;
      hs0 = ar_hs;
      pulse_npc(32'h8000_0102);
      sb.push_back('{inst: 32'd0, pc: 32'h8000_0102, err: 2'd2});
      for (int i = 0; i < 3; i++) begin
        if (arvalid) saw_ar = 1;
        if (!inst_valid) @(negedge clk);
      end
      check("misalign_no_arvalid", 32'(saw_ar), 32'd0);
      consume(1);
      check("misalign_no_handshake", 32'(ar_hs - hs0), 32'd0);
    end

    // Bus error keeps the returned data.
    pulse_npc(32'h8000_0200);
    do_fetch(1, 0, 32'hDEAD_BEEF, 2'b10, 0, 32'h8000_0200);

    // Reset while waiting for read data.
    pulse_npc(32'h8000_0300);
    begin
      int n = 0;
      while (!arvalid && n < 20) begin @(negedge clk); n++; end
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      check("rst_in_r_rready", 32'(rready), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_in_r_rready_drop", 32'(rready), 32'd0);
      check("rst_in_r_inst_valid", 32'(inst_valid), 32'd0);
      check("rst_in_r_arvalid", 32'(arvalid), 32'd0);
      check("rst_in_r_pc", pc, 32'h8000_0000);
    end
    release_reset();
    do_fetch(0, 1, 32'h0000_0013, 2'b00, 2, 32'h8000_0000);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
